uart_core: RTL and testbench

UART_CORE -- requirements
Module: uart_core

---
 rtl/uart_core.sv | 179 +++++++++++++++++
 tb/tb_uart_core.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_core.sv
// uart_core: strobe-driven 8N1 UART with rx error/overrun flags; define UART_PARITY_EN for 8E1 even parity
module uart_core #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD = 9600
) (
  input  logic       memi_clk,
  input  logic       memi_rst,
  input  logic       uart_wrn,
  input  logic       uart_rdn,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic       data_ready,
  output logic       tx_busy,
  output logic       rx_overrun,
  output logic       rx_err,
  output logic       txd,
  input  logic       rxd
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3;
`ifdef UART_PARITY_EN
  localparam logic [2:0] PARITY = 3'd4, AFTER_DATA = 3'd4;
`else
  localparam logic [2:0] AFTER_DATA = 3'd3;
`endif
  logic wrn_q, rdn_q, txd_q, txd_d, tx_tick, rx_tick, rx_in, rx_load, rx_bad, par_ok, wr_fall, rd_fall;
  logic [2:0] tx_state_q, tx_state_d, rx_state_q, rx_state_d, tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [7:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rd_data_q, rd_data_d;
  logic [1:0] rx_sync_q;
  logic data_ready_q, data_ready_d, rx_overrun_q, rx_overrun_d, rx_err_q, rx_err_d;
`ifdef UART_PARITY_EN
  logic tx_par_q, tx_par_d, rx_par_q, rx_par_d;
  assign par_ok = rx_par_q == ^rx_sh_q;
`else
  assign par_ok = 1'b1;
`endif
  assign wr_fall = wrn_q & ~uart_wrn;
  assign rd_fall = rdn_q & ~uart_rdn;
  assign rx_in = rx_sync_q[1];
  assign tx_tick = tx_cnt_q == LAST;
  assign rx_tick = rx_cnt_q == (rx_state_q == START ? HALF : LAST);
  always_comb begin
    tx_state_d = tx_state_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d = tx_sh_q;
`ifdef UART_PARITY_EN
    tx_par_d = tx_par_q;
`endif
    tx_cnt_d = (tx_state_q == IDLE || tx_tick) ? '0 : tx_cnt_q + 1'b1;
    if (tx_state_q == IDLE) begin
      if (wr_fall) begin
        tx_state_d = START;
        tx_sh_d = wr_data;
`ifdef UART_PARITY_EN
        tx_par_d = ^wr_data;
`endif
      end
    end else if (tx_tick) begin
      case (tx_state_q)
        START: begin
          tx_state_d = DATA;
          tx_bit_d = '0;
        end
        DATA: begin
          tx_sh_d = tx_sh_q >> 1;
          tx_bit_d = tx_bit_q + 1'b1;
          tx_state_d = tx_bit_q == 3'd7 ? AFTER_DATA : DATA;
        end
`ifdef UART_PARITY_EN
        PARITY: tx_state_d = STOP;
`endif
        default: tx_state_d = IDLE;
      endcase
    end
    txd_d = tx_state_d == START ? 1'b0 :
            tx_state_d == DATA ? tx_sh_d[0] :
`ifdef UART_PARITY_EN
            tx_state_d == PARITY ? tx_par_d :
`endif
            1'b1;
  end
  always_comb begin
    rx_state_d = rx_state_q;
    rx_bit_d = rx_bit_q;
    rx_sh_d = rx_sh_q;
`ifdef UART_PARITY_EN
    rx_par_d = rx_par_q;
`endif
    rx_load = 1'b0;
    rx_bad = 1'b0;
    rx_cnt_d = (rx_state_q == IDLE || rx_tick) ? '0 : rx_cnt_q + 1'b1;
    if (rx_state_q == IDLE) begin
      if (!rx_in) rx_state_d = START;
    end else if (rx_tick) begin
      case (rx_state_q)
        START: begin
          rx_state_d = rx_in ? IDLE : DATA;
          rx_bit_d = '0;
        end
        DATA: begin
          rx_sh_d = {rx_in, rx_sh_q[7:1]};
          rx_bit_d = rx_bit_q + 1'b1;
          rx_state_d = rx_bit_q == 3'd7 ? AFTER_DATA : DATA;
        end
`ifdef UART_PARITY_EN
        PARITY: begin
          rx_par_d = rx_in;
          rx_state_d = STOP;
        end
`endif
        STOP: begin
          rx_load = rx_in & par_ok;
          rx_bad = ~(rx_in & par_ok);
          rx_state_d = IDLE;
        end
        default: rx_state_d = IDLE;
      endcase
    end
    rd_data_d = rx_load ? rx_sh_q : rd_data_q;
    data_ready_d = rx_load | (data_ready_q & ~rd_fall);
    rx_overrun_d = ~rd_fall & (rx_overrun_q | (rx_load & data_ready_q));
    rx_err_d = rx_bad | (rx_err_q & ~rd_fall);
  end
  always_ff @(posedge memi_clk or negedge memi_rst) begin
    if (!memi_rst) begin
      wrn_q <= 1'b1;
      rdn_q <= 1'b1;
      rx_sync_q <= 2'b11;
      txd_q <= 1'b1;
      tx_state_q <= IDLE;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q <= '0;
      rx_state_q <= IDLE;
      rx_cnt_q <= '0;
      rx_bit_q <= '0;
      rx_sh_q <= '0;
      rd_data_q <= '0;
      data_ready_q <= 1'b0;
      rx_overrun_q <= 1'b0;
      rx_err_q <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par_q <= 1'b0;
      rx_par_q <= 1'b0;
`endif
    end else begin
      wrn_q <= uart_wrn;
      rdn_q <= uart_rdn;
      rx_sync_q <= {rx_sync_q[0], rxd};
      txd_q <= txd_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q <= tx_cnt_d;
      tx_bit_q <= tx_bit_d;
      tx_sh_q <= tx_sh_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q <= rx_cnt_d;
      rx_bit_q <= rx_bit_d;
      rx_sh_q <= rx_sh_d;
      rd_data_q <= rd_data_d;
      data_ready_q <= data_ready_d;
      rx_overrun_q <= rx_overrun_d;
      rx_err_q <= rx_err_d;
`ifdef UART_PARITY_EN
      tx_par_q <= tx_par_d;
      rx_par_q <= rx_par_d;
`endif
    end
  end
  assign txd = txd_q;
  assign tx_busy = tx_state_q != IDLE;
  assign rd_data = rd_data_q;
  assign data_ready = data_ready_q;
  assign rx_overrun = rx_overrun_q;
  assign rx_err = rx_err_q;
endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: scoreboard bench for uart_core at CLK_HZ=16, BAUD=1
module tb_uart_core;
  localparam int DIV = 16;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  logic memi_clk = 1'b0, memi_rst = 1'b0, uart_wrn = 1'b1, uart_rdn = 1'b1, rxd = 1'b1;
  logic [7:0] wr_data = 8'h00, rd_data;
  logic data_ready, tx_busy, rx_overrun, rx_err, txd;
  int checks = 0, errors = 0, cyc = 0;
  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp_b[$];
  int rx_exp_t[$];
  uart_core #(.CLK_HZ(16), .BAUD(1)) dut (
    .memi_clk(memi_clk), .memi_rst(memi_rst), .uart_wrn(uart_wrn), .uart_rdn(uart_rdn),
    .wr_data(wr_data), .rd_data(rd_data), .data_ready(data_ready), .tx_busy(tx_busy),
    .rx_overrun(rx_overrun), .rx_err(rx_err), .txd(txd), .rxd(rxd)
  );
  always #5 memi_clk = ~memi_clk;
  always @(posedge memi_clk) cyc <= cyc + 1;
  function automatic logic [NB-1:0] mk(input logic [7:0] b, input logic stop, input logic par);
`ifdef UART_PARITY_EN
    mk = {stop, par, b, 1'b0};
`else
    mk = {stop, b, 1'b0} | {NB{1'b0 & par}};
`endif
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic wr(input logic [7:0] b, input logic acc);
    @(negedge memi_clk);
    wr_data = b;
    uart_wrn = 1'b0;
    if (acc) tx_exp.push_back(b);
    @(negedge memi_clk);
    if (acc) chk("tx_busy_rise", tx_busy, 1);
    repeat (2) @(negedge memi_clk);
    uart_wrn = 1'b1;
  endtask
  task automatic rd_pulse();
    @(negedge memi_clk);
    uart_rdn = 1'b0;
    @(negedge memi_clk);
    uart_rdn = 1'b1;
  endtask
  task automatic rx_send(input logic [7:0] b, input logic stop, input logic par, input logic good);
    logic [NB-1:0] f;
    f = mk(b, stop, par);
    @(negedge memi_clk);
    if (good) begin
      rx_exp_b.push_back(b);
      rx_exp_t.push_back(cyc);
    end
    for (int i = 0; i < NB; i++) begin
      rxd = f[i];
      repeat (DIV) @(negedge memi_clk);
    end
    rxd = 1'b1;
  endtask
  task automatic wait_idle();
    int n;
    n = 0;
    while (tx_busy && n < 400) begin
      @(negedge memi_clk);
      n++;
    end
    chk("tx_idle_timeout", tx_busy, 0);
  endtask
  initial begin : tx_mon
    logic prev, ok, ab, gv;
    logic [NB-1:0] f;
    logic [7:0] b;
    int gc;
    prev = 1'b1;
    forever begin
      @(negedge memi_clk);
      if (memi_rst && prev && !txd) begin
        if (tx_exp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_frame got start bit, expected no frame");
        end else begin
          b = tx_exp.pop_front();
          f = mk(b, 1'b1, ^b);
          ok = 1'b1;
          ab = 1'b0;
          gc = 0;
          gv = 1'b0;
          for (int c = 0; c < NB * DIV; c++) begin
            if (c > 0) @(negedge memi_clk);
            if (!memi_rst) begin
              ab = 1'b1;
              break;
            end
            if (ok && (txd !== f[c/DIV] || tx_busy !== 1'b1)) begin
              ok = 1'b0;
              gc = c;
              gv = txd;
            end
          end
          if (!ab) begin
            @(negedge memi_clk);
            if (ok && (txd !== 1'b1 || tx_busy !== 1'b0)) begin
              ok = 1'b0;
              gc = NB * DIV;
              gv = txd;
            end
            checks++;
            if (!ok) begin
              errors++;
              $display("FAIL tx_frame byte %h cycle %0d got txd=%b busy=%b expected frame %b (LSB first)", b, gc, gv, tx_busy, f);
            end
          end
        end
      end
      prev = txd;
    end
  end
  initial begin : rx_mon
    logic pd;
    logic [7:0] pr, eb;
    int et, dt;
    pd = 1'b0;
    pr = 8'h00;
    forever begin
      @(negedge memi_clk);
      if (memi_rst && data_ready && (!pd || rd_data !== pr)) begin
        checks++;
        if (rx_exp_b.size() == 0) begin
          errors++;
          $display("FAIL rx_byte got %h, expected no byte", rd_data);
        end else begin
          eb = rx_exp_b.pop_front();
          et = rx_exp_t.pop_front();
          dt = cyc - et;
          if (rd_data !== eb || dt < (NB - 1) * DIV || dt > NB * DIV + 2) begin
            errors++;
            $display("FAIL rx_byte got %h at %0d cycles expected %h within [%0d,%0d]", rd_data, dt, eb, (NB - 1) * DIV, NB * DIV + 2);
          end
        end
      end
      pd = data_ready;
      pr = rd_data;
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge memi_clk);
    chk("rst_txd", txd, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_dr", data_ready, 0);
    chk("rst_ov", rx_overrun, 0);
    chk("rst_err", rx_err, 0);
    chk("rst_rd", rd_data, 0);
    memi_rst = 1'b1;
    repeat (2) @(negedge memi_clk);
    wr(8'hA5, 1'b1);
    wait_idle();
    wr(8'h5A, 1'b1);
    repeat (20) @(negedge memi_clk);
    fork
      wr(8'hFF, 1'b0);
      begin
        rxd = 1'b0;
        repeat (5) @(negedge memi_clk);
        rxd = 1'b1;
      end
    join
    wait_idle();
    repeat (30) @(negedge memi_clk);
    chk("ignored_wr_busy", tx_busy, 0);
    chk("glitch_dr", data_ready, 0);
    chk("glitch_err", rx_err, 0);
    rx_send(8'h3C, 1'b1, ^8'h3C, 1'b1);
    chk("rx3c_dr", data_ready, 1);
    rd_pulse();
    chk("rx3c_dr_clr", data_ready, 0);
    chk("rx3c_rd_keep", rd_data, 8'h3C);
    rx_send(8'h11, 1'b1, ^8'h11, 1'b1);
    rx_send(8'h22, 1'b1, ^8'h22, 1'b1);
    chk("ovr_rd", rd_data, 8'h22);
    chk("ovr_flag", rx_overrun, 1);
    chk("ovr_dr", data_ready, 1);
    rd_pulse();
    chk("ovr_dr_clr", data_ready, 0);
    chk("ovr_flag_clr", rx_overrun, 0);
    rx_send(8'h77, 1'b0, ^8'h77, 1'b0);
    repeat (20) @(negedge memi_clk);
    chk("stop0_err", rx_err, 1);
    chk("stop0_dr", data_ready, 0);
    chk("stop0_rd", rd_data, 8'h22);
    rd_pulse();
    chk("stop0_err_clr", rx_err, 0);
`ifdef UART_PARITY_EN
    rx_send(8'h01, 1'b1, 1'b0, 1'b0);
    repeat (20) @(negedge memi_clk);
    chk("par_err", rx_err, 1);
    chk("par_dr", data_ready, 0);
    rd_pulse();
`endif
    fork
      wr(8'hC3, 1'b1);
      rx_send(8'h96, 1'b1, ^8'h96, 1'b1);
    join
    wait_idle();
    chk("duplex_rd", rd_data, 8'h96);
    wr(8'h0F, 1'b1);
    repeat (85) @(negedge memi_clk);
    #3 memi_rst = 1'b0;
    #1;
    chk("mid_rst_txd", txd, 1);
    chk("mid_rst_busy", tx_busy, 0);
    chk("mid_rst_rd", rd_data, 0);
    chk("mid_rst_dr", data_ready, 0);
    repeat (2) @(negedge memi_clk);
    memi_rst = 1'b1;
    @(negedge memi_clk);
    wr(8'hE1, 1'b1);
    wait_idle();
    repeat (10) @(negedge memi_clk);
    chk("tx_queue_drained", tx_exp.size(), 0);
    chk("rx_queue_drained", rx_exp_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
